// File: rtl/memory_feeder.sv
// Memory-mapped stream source: serves a parameter-initialised word array to CPU
// loads, advanced by CPU writes to the DATA register, with underrun accounting.
module memory_feeder #(
   parameter int addr_size  = 8,
   parameter int word_size  = 8,
   parameter int array_size = 4,
   parameter logic [addr_size-1:0] base_addr = 8'h80,
   parameter logic [array_size*word_size-1:0] array_content = 32'h0806_0402
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [addr_size-1:0] addr,
   input  logic [word_size-1:0] data_in,
   input  logic                 write_en,
   output logic [word_size-1:0] data_out,
   output logic                 exhausted,
   output logic                 underrun
);

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

   localparam logic [word_size-1:0] size_w = word_size'(array_size);

   logic [word_size-1:0] index;
   logic [word_size-1:0] uflow;
   logic [word_size-1:0] cur_word;
   logic [word_size-1:0] rd_data;
   logic [addr_size-1:0] offset;
   logic [1:0]           sel;
   logic                 in_window;
   logic                 wr_hit;
   logic                 unused_data_bits;

   // Modular subtraction makes a window that straddles the top of the address
   // space wrap naturally; the offset is inside the window when it is below 4.
   assign offset    = addr - base_addr;
   assign in_window = (offset[addr_size-1:2] == '0);
   assign sel       = offset[1:0];
   assign wr_hit    = write_en && in_window;

   assign exhausted = (index == size_w);
   assign underrun  = (uflow != '0);

   // Only bit 0 of a CTRL write carries meaning.
   assign unused_data_bits = ^data_in[word_size-1:1];

   always_comb begin
      cur_word = '0;
      for (int i = 0; i < array_size; i++) begin
         if (index == word_size'(i)) begin
            cur_word = array_content[i*word_size +: word_size];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      if (in_window) begin
         case (sel)
            REG_DATA:   rd_data = cur_word;
            REG_STATUS: rd_data = size_w - index;
            REG_CTRL:   rd_data = uflow;
            default:    rd_data = '0;
         endcase
      end
   end

   // Read data is taken from pre-update state, so a same-cycle DATA read and
   // write returns the old word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         index    <= '0;
         uflow    <= '0;
         data_out <= '0;
      end else begin
         data_out <= rd_data;
         if (wr_hit) begin
            case (sel)
               REG_DATA: begin
                  if (!exhausted) begin
                     index <= index + 1'b1;
                  end else if (uflow != '1) begin
                     uflow <= uflow + 1'b1;
                  end
               end
               REG_CTRL: begin
                  if (data_in[0]) begin
                     index <= '0;
                     uflow <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_memory_feeder.sv
// Directed bench for memory_feeder: expected read data queued at stimulus time,
// popped and compared one cycle later when the registered read data appears.
module tb_memory_feeder;

   logic       clk;
   logic       reset;
   logic [7:0] addr;
   logic [7:0] data_in;
   logic       write_en;
   logic [7:0] data_out;
   logic       exhausted;
   logic       underrun;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] exp_q[$];
   string      tag_q[$];

   memory_feeder dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .data_in   (data_in),
      .write_en  (write_en),
      .data_out  (data_out),
      .exhausted (exhausted),
      .underrun  (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive on the falling edge, sample 1 ns after the rising edge.
   task automatic bus(input logic [7:0] a, input logic we, input logic [7:0] d,
                      input logic chk, input logic [7:0] exp, input string tag);
      logic [7:0] e;
      string      t;
      @(negedge clk);
      addr     = a;
      write_en = we;
      data_in  = d;
      if (chk) begin
         exp_q.push_back(exp);
         tag_q.push_back(tag);
      end
      @(posedge clk);
      #1;
      write_en = 1'b0;
      if (chk) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check(t, data_out, e);
      end
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
      bus(a, 1'b0, 8'h00, 1'b1, exp, tag);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      bus(a, 1'b1, d, 1'b0, 8'h00, "");
   endtask

   initial begin
      reset    = 1'b1;
      addr     = 8'h00;
      data_in  = 8'h00;
      write_en = 1'b0;
      #1;
      check("rst_data_out", data_out, 8'h00);
      check("rst_exhausted", {7'b0, exhausted}, 8'h00);
      check("rst_underrun", {7'b0, underrun}, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      rd(8'h80, 8'h02, "first_data");
      rd(8'h81, 8'h04, "first_status");
      check("not_exhausted", {7'b0, exhausted}, 8'h00);

      for (int i = 0; i < 4; i++) begin
         rd(8'h80, 8'(2 * (i + 1)), $sformatf("stream_word%0d", i));
         wr(8'h80, 8'hA5);
      end
      rd(8'h81, 8'h00, "status_empty");
      check("exhausted_set", {7'b0, exhausted}, 8'h01);
      rd(8'h80, 8'h00, "data_after_end");

      wr(8'h80, 8'h00);
      wr(8'h80, 8'h00);
      rd(8'h82, 8'h02, "uflow_two");
      check("underrun_set", {7'b0, underrun}, 8'h01);
      rd(8'h81, 8'h00, "status_stays0");

      for (int i = 0; i < 300; i++) wr(8'h80, 8'h00);
      rd(8'h82, 8'hFF, "uflow_saturated");

      wr(8'h82, 8'h01);
      rd(8'h81, 8'h04, "rewind_status");
      rd(8'h82, 8'h00, "rewind_uflow");
      check("rewind_underrun", {7'b0, underrun}, 8'h00);
      check("rewind_exhausted", {7'b0, exhausted}, 8'h00);
      rd(8'h80, 8'h02, "rewind_data");
      wr(8'h82, 8'h00);
      wr(8'h82, 8'hFE);
      rd(8'h81, 8'h04, "ctrl_zero_ignored");
      rd(8'h80, 8'h02, "ctrl_zero_data");

      wr(8'h80, 8'h00);
      bus(8'h80, 1'b1, 8'h33, 1'b1, 8'h04, "same_cycle_rdwr");
      rd(8'h80, 8'h06, "after_same_cycle");
      rd(8'h7F, 8'h00, "below_window");
      rd(8'h83, 8'h00, "reserved_reg");
      rd(8'h84, 8'h00, "above_window");
      wr(8'h7F, 8'h01);
      wr(8'h84, 8'h01);
      wr(8'h81, 8'h01);
      wr(8'h83, 8'h01);
      rd(8'h81, 8'h02, "no_state_change");

      wr(8'h80, 8'h00);
      rd(8'h80, 8'h08, "index3_data");
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_data_out", data_out, 8'h00);
      check("async_rst_exhausted", {7'b0, exhausted}, 8'h00);
      check("async_rst_underrun", {7'b0, underrun}, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      rd(8'h80, 8'h02, "post_reset_data");
      rd(8'h81, 8'h04, "post_reset_status");

      for (int i = 0; i < 5; i++) wr(8'h80, 8'h00);
      check("pre_rst2_exhausted", {7'b0, exhausted}, 8'h01);
      check("pre_rst2_underrun", {7'b0, underrun}, 8'h01);
      #2;
      reset = 1'b1;
      #1;
      check("rst2_exhausted", {7'b0, exhausted}, 8'h00);
      check("rst2_underrun", {7'b0, underrun}, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      rd(8'h82, 8'h00, "rst2_uflow");

      check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
